keypad_event_fifo: RTL and testbench
====================================

# keypad_event_fifo

Debounced keypad event capture queue sitting between the `Keypad` scanner and the pipelined CPU's memory-mapped I/O path. It converts the scanner's level-style `KeypadData` into one event per debounced key press and queues up to `DEPTH` key codes. It drives a level interrupt request into the CPU's `intr` input. Software drains the queue through three word registers decoded from the CPU's memory-stage address and store-enable signals.

## Interface
- `DEPTH`, 8, number of FIFO entries; must be a power of two, 2..16.
- `DEBOUNCE`, 16, consecutive identical `KeypadData` samples required before a value is accepted as stable; range 2..255.
- `Clock`  input  1  single clock, rising edge; same divided clock as `Keypad`.
- `Reset`  input  1  synchronous, active-high reset.
- `KeypadData`  input  8  scanner output; 8'h00 means no key, any other value is a key code.
- `RegSel`  input  2  register select; 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- `Rd`  input  1  one-cycle read strobe for the register selected by `RegSel`.
- `Wr`  input  1  one-cycle write strobe for the register selected by `RegSel`.
- `WData`  input  8  write data; only CTRL is writable.
- `RData`  output  32  registered read data.
- `Intr`  output  1  level interrupt request to the CPU.

## Operation
- **Debounce.**
  - `sample` register holds the previous `KeypadData`. `stab_cnt` (8-bit) resets to 0 whenever `KeypadData != sample`; otherwise it increments, saturating at `DEBOUNCE`.
  - When `stab_cnt` reaches `DEBOUNCE-1` while `KeypadData == sample`, `sample` is copied into `stable`.
- **Event generation.** A push event occurs on the cycle `stable` changes to a non-zero value.
  - This covers both 0 -> code and codeA -> codeB.
  - A change to 0 (release) produces no event.
  - Holding a key produces exactly one event.
- **FIFO.**
  - Storage is `DEPTH` x 8 bits, with wrap-around `wr_ptr`/`rd_ptr` and a `count` of width clog2(`DEPTH`)+1.
  - Push when full: the code is dropped, sticky `ovf` is set, and pointers are unchanged.
  - Pop when empty: no pointer change.
  - Push and pop in the same cycle when non-empty: both take effect and `count` is unchanged.
  - Push and pop in the same cycle when empty: the pop returns empty and the push is stored.
  - Push and pop in the same cycle when full: the pop frees a slot, the push is stored, and `ovf` is not set.
- **DATA read** (`Rd` and `RegSel`=0):
  - Non-empty: `RData` <= {23'b0, 1'b1, head_code} and the FIFO pops.
  - Empty: `RData` <= 32'h0000_0000.
- **STATUS read** (`RegSel`=1): `RData` <= {19'b0, count[4:0] zero-extended, 4'b0, ien, ovf, full, empty}. Bit 0 is `empty`, bits 12:8 hold `count`. This read has no side effects.
- **CTRL read** (`RegSel`=2): `RData` <= {31'b0, ien}.
- **CTRL write** (`Wr` and `RegSel`=2):
  - bit0 -> `ien`.
  - bit1 = 1 clears `ovf`.
  - bit2 = 1 flushes the FIFO: pointers and count go to 0.
  - A flush in the same cycle as a push: the flush wins and the pushed code is discarded.
  - A clear of `ovf` in the same cycle as an overflowing push: the set wins.
- **Reserved register** (`RegSel`=3): reads return 0; writes are ignored.
- **Simultaneous strobes.** `Rd` and `Wr` in the same cycle are both honoured.
- **Interrupt.** `Intr` = `ien` & ~`empty`, registered.

## Timing
- **Reset values.**
  - `RData`=0, `Intr`=0.
  - `ien`=0, `ovf`=0.
  - Pointers, `count`, `sample`, `stable`, and `stab_cnt` are all 0.
- **Reset mid-operation.** Reset discards queued codes and any in-progress debounce. After reset, a key that is still held is captured as a new event once it has been stable for `DEBOUNCE` cycles.
- **Latency, key to storage.** A key value held from cycle t is committed to `stable` at the end of cycle t+`DEBOUNCE`-1. It is written to storage, with `count` updated, on the following edge.
- **`Intr` latency.** `Intr` rises 1 cycle after `count` becomes non-zero with `ien`=1, and falls 1 cycle after the pop that empties the FIFO.
- **Read latency.** Registers are read with 1-cycle latency: `RData` is valid the cycle after `Rd` and holds its value until the next `Rd`.
- **Write timing.** A CTRL write takes effect on the edge where `Wr` is sampled.
- **Strobe requirements.** `Rd`/`Wr` must be single-cycle pulses. A strobe held for N cycles performs N accesses, so a held DATA read pops N entries.

## Test plan
- **Single press.** Reset; set `ien`=1; hold `KeypadData`=8'h35 for 40 cycles, then 8'h00 -> exactly one event stored; `Intr`=1 at cycle `DEBOUNCE`+2; DATA read returns 32'h0000_0135; `Intr`=0 one cycle later; a second DATA read returns 0.
- **Bounce rejection.** Toggle 8'h12/8'h00 every 5 cycles for 100 cycles with `DEBOUNCE`=16 -> `count` stays 0 and `Intr` stays 0.
- **Overflow.** Make 10 distinct debounced presses with no reads, `DEPTH`=8 -> STATUS = `count` 8, full=1, ovf=1; DATA reads return the first 8 codes in order, then 0; writing CTRL=8'h03 clears `ovf` and keeps `ien`=1.
- **Simultaneous push/pop at full.** With the FIFO full, issue a DATA read on the same cycle as a new push -> `count` stays 8, ovf=0, and the order is preserved with the new code last.
- **Flush.** With 3 queued codes, write CTRL=8'h05 -> on the next cycle empty=1 and `count`=0, with `Intr` falling one cycle after; a push on the flush cycle is discarded.
- **Reset mid-debounce.** Assert `Reset` at cycle 10 of a held key, release it, and keep the key held -> exactly one event appears `DEBOUNCE` cycles after reset release; all outputs are 0 during reset.

Source files
------------

// File: rtl/keypad_event_fifo_if.sv
// Register-bus interface between the CPU memory-stage decode and the keypad
// event queue. The CPU side (master) drives the select and strobes; the queue
// (slave) returns registered read data and a level interrupt.
//
// Strobe semantics: Rd and Wr are single-cycle pulses qualified by RegSel.
// Every cycle a strobe is high counts as one access, with no ready or
// back-pressure. RData is registered: it is valid the cycle after Rd and
// holds until the next Rd. Intr is a level that stays high while the queue is
// non-empty and interrupts are enabled.
interface keypad_event_fifo_if;
  logic [1:0]  RegSel;
  logic        Rd;
  logic        Wr;
  logic [7:0]  WData;
  logic [31:0] RData;
  logic        Intr;

  modport master (output RegSel, Rd, Wr, WData, input RData, Intr);
  modport slave  (input RegSel, Rd, Wr, WData, output RData, Intr);
endinterface

// File: rtl/keypad_event_fifo.sv
// Debounced keypad event queue. Each debounced change of the scanner output
// to a non-zero code becomes one queued event. Software drains the queue
// through DATA (0), STATUS (1) and CTRL (2) word registers.
module keypad_event_fifo #(
  parameter int DEPTH    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [7:0]          KeypadData,
  keypad_event_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    DB_MAX    = 8'(DEBOUNCE);
  // Commit on the edge where stab_cnt advances to DEBOUNCE-1.
  localparam logic [7:0]    DB_COMMIT = 8'(DEBOUNCE - 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [7:0]    sample;
  logic [7:0]    stable;
  logic [7:0]    stab_cnt;
  logic          evt_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          ien;
  logic          ovf;
  logic [31:0]   rdata_q;
  logic          intr_q;

  logic          empty;
  logic          full;
  logic          rd_data;
  logic          wr_ctrl;
  logic          flush;
  logic          ovf_clr;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  logic [4:0]    count_ext;
  logic [31:0]   status_word;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign rd_data     = bus.Rd && (bus.RegSel == 2'd0);
  assign wr_ctrl     = bus.Wr && (bus.RegSel == 2'd2);
  assign flush       = wr_ctrl && bus.WData[2];
  assign ovf_clr     = wr_ctrl && bus.WData[1];
  assign do_pop      = rd_data && !empty;
  // A pop in the same cycle frees the slot for a push arriving at full.
  assign do_push     = evt_q && !flush && (!full || do_pop);
  assign ovf_set     = evt_q && !flush && full && !do_pop;
  assign count_ext   = 5'(count);
  assign status_word = {19'b0, count_ext, 4'b0, ien, ovf, full, empty};

  // Debounce: track the previous sample, count identical samples, and commit
  // the value to stable once it has been seen DEBOUNCE times in a row.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sample   <= 8'h00;
      stable   <= 8'h00;
      stab_cnt <= 8'h00;
      evt_q    <= 1'b0;
    end else begin
      sample <= KeypadData;
      evt_q  <= 1'b0;
      if (KeypadData != sample) begin
        stab_cnt <= 8'h00;
      end else begin
        if (stab_cnt != DB_MAX) stab_cnt <= stab_cnt + 8'd1;
        if (stab_cnt == DB_COMMIT) begin
          stable <= sample;
          evt_q  <= (sample != stable) && (sample != 8'h00);
        end
      end
    end
  end

  // Next occupancy: flush dominates, otherwise net of push and pop.
  always_comb begin
    count_nxt = count;
    if (flush)                count_nxt = '0;
    else if (do_push && !do_pop) count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
  end

  // Queue pointers, occupancy and control bits.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ien    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ctrl) ien <= bus.WData[0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Event storage; contents are only meaningful between the pointers.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= stable;
  end

  // Registered read data and interrupt level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_q <= 32'h0;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= ien && !empty;
      if (bus.Rd) begin
        case (bus.RegSel)
          2'd0:    rdata_q <= empty ? 32'h0 : {23'b0, 1'b1, mem[rd_ptr]};
          2'd1:    rdata_q <= status_word;
          2'd2:    rdata_q <= {31'b0, ien};
          default: rdata_q <= 32'h0;
        endcase
      end
    end
  end

  assign bus.RData = rdata_q;
  assign bus.Intr  = intr_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: a register-access vector table, then
// hand-written key press sequences checked against an expected-word queue.
module tb_keypad_event_fifo;

  localparam int DEPTH    = 8;
  localparam int DEBOUNCE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kd;

  keypad_event_fifo_if bus();

  keypad_event_fifo #(.DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .KeypadData (kd),
    .bus        (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic        model_ovf = 1'b0;
  logic        model_ien = 1'b0;

  typedef struct {
    logic [1:0]  sel;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic bus_op(input logic [1:0] sel, input logic rd, input logic wr, input logic [7:0] wd);
    bus.RegSel = sel;
    bus.Rd     = rd;
    bus.Wr     = wr;
    bus.WData  = wd;
    tick(1);
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [31:0] d);
    bus_op(sel, 1'b1, 1'b0, 8'h00);
    d = bus.RData;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] wd);
    bus_op(sel, 1'b0, 1'b1, wd);
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return {19'b0, 5'(n), 4'b0, model_ien, model_ovf, (n == DEPTH), (n == 0)};
  endfunction

  // Scoreboard: compare a DATA read against the oldest expected word.
  task automatic data_read(input string name);
    logic [31:0] e;
    logic [31:0] d;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    reg_read(2'd0, d);
    check(name, d, e);
  endtask

  task automatic status_check(input string name);
    logic [31:0] e;
    logic [31:0] d;
    e = exp_status();
    reg_read(2'd1, d);
    check(name, d, e);
  endtask

  // One clean debounced press followed by a clean release.
  task automatic press(input logic [7:0] code);
    kd = code;
    if (exp_q.size() < DEPTH) exp_q.push_back({23'b0, 1'b1, code});
    else model_ovf = 1'b1;
    tick(DEBOUNCE + 4);
    kd = 8'h00;
    tick(DEBOUNCE + 4);
  endtask

  initial begin
    logic [31:0] d;

    rst = 1'b1;
    kd  = 8'h00;
    bus.RegSel = 2'd0;
    bus.Rd     = 1'b0;
    bus.Wr     = 1'b0;
    bus.WData  = 8'h00;
    tick(3);
    check("reset_rdata", bus.RData, 32'h0);
    check("reset_intr", {31'b0, bus.Intr}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Register access table: {sel, rd, wr, wdata, expected RData after op}
    vecs[0]  = '{2'd2, 1'b1, 1'b0, 8'h00, 32'h0};        // CTRL reads ien=0
    vecs[1]  = '{2'd2, 1'b0, 1'b1, 8'h01, 32'h0};        // write ien, RData held
    vecs[2]  = '{2'd2, 1'b1, 1'b0, 8'h00, 32'h1};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 8'h00, 32'h9};        // ien + empty
    vecs[4]  = '{2'd3, 1'b1, 1'b0, 8'h00, 32'h0};        // reserved reads 0
    vecs[5]  = '{2'd3, 1'b0, 1'b1, 8'hff, 32'h0};        // reserved write ignored
    vecs[6]  = '{2'd2, 1'b1, 1'b0, 8'h00, 32'h1};
    vecs[7]  = '{2'd2, 1'b1, 1'b1, 8'h00, 32'h1};        // rd+wr: read sees old ien
    vecs[8]  = '{2'd2, 1'b1, 1'b0, 8'h00, 32'h0};
    vecs[9]  = '{2'd1, 1'b1, 1'b0, 8'h00, 32'h1};        // empty only
    vecs[10] = '{2'd2, 1'b0, 1'b1, 8'h01, 32'h1};        // RData held
    vecs[11] = '{2'd0, 1'b1, 1'b0, 8'h00, 32'h0};        // DATA on empty
    for (int i = 0; i < 12; i++) begin
      bus_op(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
      check($sformatf("vec%0d", i), bus.RData, vecs[i].exp_rdata);
    end
    model_ien = 1'b1;

    // Single press with interrupt timing
    kd = 8'h35;
    exp_q.push_back(32'h0000_0135);
    tick(DEBOUNCE + 1);
    check("single_intr_early", {31'b0, bus.Intr}, 32'h0);
    tick(1);
    check("single_intr_rise", {31'b0, bus.Intr}, 32'h1);
    tick(40 - DEBOUNCE - 2);
    kd = 8'h00;
    tick(DEBOUNCE + 4);
    status_check("single_status");
    data_read("single_data");
    check("single_intr_hold", {31'b0, bus.Intr}, 32'h1);
    tick(1);
    check("single_intr_fall", {31'b0, bus.Intr}, 32'h0);
    data_read("single_empty");

    // Bounce rejection
    for (int i = 0; i < 20; i++) begin
      kd = (i % 2 == 0) ? 8'h12 : 8'h00;
      tick(5);
      check($sformatf("bounce_intr%0d", i), {31'b0, bus.Intr}, 32'h0);
    end
    kd = 8'h00;
    tick(DEBOUNCE + 4);
    status_check("bounce_status");

    // Overflow: ten presses into eight slots
    for (int i = 0; i < 10; i++) press(8'h41 + 8'(i));
    status_check("ovf_status");
    for (int i = 0; i < 9; i++) data_read($sformatf("ovf_data%0d", i));
    reg_write(2'd2, 8'h03);
    model_ovf = 1'b0;
    status_check("ovf_cleared");

    // Push and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++) press(8'h51 + 8'(i));
    status_check("full_status");
    kd = 8'h59;
    tick(DEBOUNCE);
    data_read("simul_pop");
    exp_q.push_back(32'h0000_0159);
    tick(4);
    kd = 8'h00;
    tick(DEBOUNCE + 4);
    status_check("simul_status");
    for (int i = 0; i < DEPTH + 1; i++) data_read($sformatf("simul_data%0d", i));

    // Flush with a push on the same edge
    for (int i = 0; i < 3; i++) press(8'h61 + 8'(i));
    check("flush_intr_pre", {31'b0, bus.Intr}, 32'h1);
    kd = 8'h64;
    tick(DEBOUNCE);
    reg_write(2'd2, 8'h05);
    exp_q.delete();
    check("flush_intr_lag", {31'b0, bus.Intr}, 32'h1);
    status_check("flush_status");
    check("flush_intr_fall", {31'b0, bus.Intr}, 32'h0);
    tick(4);
    kd = 8'h00;
    tick(DEBOUNCE + 4);
    data_read("flush_data");

    // Reset in the middle of a debounce
    reg_read(2'd2, d);
    check("pre_reset_ctrl", d, 32'h1);
    kd = 8'h77;
    tick(10);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("rst_rdata%0d", i), bus.RData, 32'h0);
      check($sformatf("rst_intr%0d", i), {31'b0, bus.Intr}, 32'h0);
    end
    rst = 1'b0;
    exp_q.delete();
    model_ien = 1'b0;
    model_ovf = 1'b0;
    tick(DEBOUNCE);
    status_check("rst_not_yet");
    exp_q.push_back(32'h0000_0177);
    status_check("rst_event");
    check("rst_intr_off", {31'b0, bus.Intr}, 32'h0);
    tick(20);
    kd = 8'h00;
    tick(DEBOUNCE + 4);
    status_check("rst_one_event");
    data_read("rst_data");
    data_read("rst_empty");

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
